// File: rtl/module_teclado_captura.sv
// rtl/module_teclado_captura.sv - 4x4 keypad scanner, debouncer, decoder and operand capture
module module_teclado_captura #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fila,
    output logic [3:0] columna,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       load_a,
    output logic       load_b,
    output logic       load_m
);
    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_TARGET = DW'(DEBOUNCE);
    localparam logic [DW-1:0] DEB_ONE    = DW'(1);
    localparam logic [3:0]    KEY_STAR   = 4'd14;
    localparam logic [3:0]    KEY_HASH   = 4'd15;

    typedef enum logic [1:0] {SCAN, DEBO, HOLD, RELEASE} scan_state_t;
    typedef enum logic [1:0] {CAP_A, CAP_B, CAP_EQ, CAP_RES} cap_state_t;

    function automatic logic [3:0] decode_key(input logic [3:0] r_pat, input logic [3:0] c_pat);
        logic [1:0] r_idx;
        logic [1:0] c_idx;
        logic [3:0] code;
        r_idx = 2'd0;
        c_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!r_pat[i]) r_idx = 2'(i);
            if (!c_pat[i]) c_idx = 2'(i);
        end
        case ({r_idx, c_idx})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = 4'd10;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = 4'd11;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = 4'd12;
            4'hC: code = 4'd14;
            4'hD: code = 4'd0;
            4'hE: code = 4'd15;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

    // fila is asynchronous to clk; everything downstream sees only rows
    logic [3:0] fila_meta;
    logic [3:0] rows;

    always_ff @(posedge clk) begin
        if (rst) begin
            fila_meta <= 4'hF;
            rows      <= 4'hF;
        end else begin
            fila_meta <= fila;
            rows      <= fila_meta;
        end
    end

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    logic rows_idle;
    logic one_low;

    assign rows_idle = (rows == 4'hF);
    assign one_low   = (rows == 4'b1110) || (rows == 4'b1101) ||
                       (rows == 4'b1011) || (rows == 4'b0111);

    scan_state_t   scan_state, scan_next;
    logic [DW-1:0] deb_cnt, deb_cnt_next, deb_inc;
    logic [3:0]    row_pat, row_pat_next;
    logic [3:0]    columna_next;
    logic          key_valid_next;
    logic [3:0]    key_code_next;

    assign deb_inc = deb_cnt + 1'b1;

    always_comb begin
        scan_next      = scan_state;
        deb_cnt_next   = deb_cnt;
        row_pat_next   = row_pat;
        columna_next   = columna;
        key_valid_next = 1'b0;
        key_code_next  = key_code;
        case (scan_state)
            SCAN: begin
                if (tick) begin
                    if (rows_idle) begin
                        columna_next = {columna[2:0], columna[3]};
                    end else if (one_low) begin
                        row_pat_next = rows;
                        deb_cnt_next = DEB_ONE;
                        if (DEB_ONE >= DEB_TARGET) begin
                            scan_next      = HOLD;
                            key_valid_next = 1'b1;
                            key_code_next  = decode_key(rows, columna);
                        end else begin
                            scan_next = DEBO;
                        end
                    end else begin
                        deb_cnt_next = '0;
                        scan_next    = RELEASE;
                    end
                end
            end
            DEBO: begin
                if (tick) begin
                    if (rows == row_pat) begin
                        deb_cnt_next = deb_inc;
                        if (deb_inc >= DEB_TARGET) begin
                            scan_next      = HOLD;
                            key_valid_next = 1'b1;
                            key_code_next  = decode_key(row_pat, columna);
                        end
                    end else begin
                        deb_cnt_next = '0;
                        scan_next    = SCAN;
                    end
                end
            end
            HOLD: begin
                deb_cnt_next = '0;
                scan_next    = RELEASE;
            end
            default: begin
                // Column stays frozen until the keypad has been idle long enough
                if (tick) begin
                    if (!rows_idle) begin
                        deb_cnt_next = '0;
                    end else if (deb_inc >= DEB_TARGET) begin
                        deb_cnt_next = '0;
                        scan_next    = SCAN;
                    end else begin
                        deb_cnt_next = deb_inc;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_state <= SCAN;
            deb_cnt    <= '0;
            row_pat    <= 4'hF;
            columna    <= 4'b1110;
            key_valid  <= 1'b0;
            key_code   <= 4'd0;
        end else begin
            scan_state <= scan_next;
            deb_cnt    <= deb_cnt_next;
            row_pat    <= row_pat_next;
            columna    <= columna_next;
            key_valid  <= key_valid_next;
            key_code   <= key_code_next;
        end
    end

    cap_state_t cap_state, cap_next;
    logic [3:0] a_next, b_next;
    logic       load_a_next, load_b_next, load_m_next;
    logic       is_digit;

    assign is_digit = (key_code <= 4'd9);

    always_comb begin
        cap_next    = cap_state;
        a_next      = a;
        b_next      = b;
        load_a_next = 1'b0;
        load_b_next = 1'b0;
        load_m_next = 1'b0;
        if (key_valid) begin
            if (key_code == KEY_STAR) begin
                a_next   = 4'd0;
                b_next   = 4'd0;
                cap_next = CAP_A;
            end else begin
                case (cap_state)
                    CAP_A, CAP_RES: begin
                        if (is_digit) begin
                            a_next      = key_code;
                            load_a_next = 1'b1;
                            cap_next    = CAP_B;
                        end
                    end
                    CAP_B: begin
                        if (is_digit) begin
                            b_next      = key_code;
                            load_b_next = 1'b1;
                            cap_next    = CAP_EQ;
                        end
                    end
                    default: begin
                        if (key_code == KEY_HASH) begin
                            load_m_next = 1'b1;
                            cap_next    = CAP_RES;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_state <= CAP_A;
            a         <= 4'd0;
            b         <= 4'd0;
            load_a    <= 1'b0;
            load_b    <= 1'b0;
            load_m    <= 1'b0;
        end else begin
            cap_state <= cap_next;
            a         <= a_next;
            b         <= b_next;
            load_a    <= load_a_next;
            load_b    <= load_b_next;
            load_m    <= load_m_next;
        end
    end
endmodule

// File: tb/tb_module_teclado_captura.sv
// tb/tb_module_teclado_captura.sv - self-checking bench for module_teclado_captura
module tb_module_teclado_captura;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  fila;
    logic [3:0]  columna;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        load_a;
    logic        load_b;
    logic        load_m;
    logic [15:0] pressed = 16'h0;

    module_teclado_captura #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk), .rst(rst), .fila(fila), .columna(columna),
        .key_valid(key_valid), .key_code(key_code), .a(a), .b(b),
        .load_a(load_a), .load_b(load_b), .load_m(load_m)
    );

    always #5 clk = ~clk;

    // Passive keypad: a row reads low when a pressed key sits on a driven-low column
    always_comb begin
        fila = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !columna[c]) fila[r] = 1'b0;
    end

    int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    function automatic int key_index(input int code);
        int idx;
        idx = 0;
        for (int i = 0; i < 16; i++) if (keymap[i] == code) idx = i;
        return idx;
    endfunction

    int         kv_cnt = 0, la_cnt = 0, lb_cnt = 0, lm_cnt = 0, lat_err = 0, multi_err = 0;
    logic [3:0] last_code = 4'd0;
    logic       kv_prev = 1'b0;

    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt++;
            last_code = key_code;
        end
        if ((load_a || load_b || load_m) && !kv_prev) lat_err++;
        if (int'(load_a) + int'(load_b) + int'(load_m) > 1) multi_err++;
        if (load_a) la_cnt++;
        if (load_b) lb_cnt++;
        if (load_m) lm_cnt++;
        kv_prev = key_valid;
    end

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Calculator-level reference: operand slots filled in order, '#' only once both are set
    int m_a = 0, m_b = 0, m_have_a = 0, m_have_b = 0, m_done = 0;

    task automatic model_reset();
        m_a = 0; m_b = 0; m_have_a = 0; m_have_b = 0; m_done = 0;
    endtask

    task automatic model_key(input int code, output int ld);
        ld = 0;
        if (code == 14) begin
            model_reset();
        end else if (code <= 9 && (!m_have_a || m_done)) begin
            m_a = code; m_have_a = 1; m_have_b = 0; m_done = 0; ld = 1;
        end else if (code <= 9 && !m_have_b) begin
            m_b = code; m_have_b = 1; ld = 2;
        end else if (code == 15 && m_have_a && m_have_b && !m_done) begin
            m_done = 1; ld = 3;
        end
    endtask

    task automatic press_and_check(input string tag, input int code, input int exp_a,
                                   input int exp_b, input int exp_ld, input int hold_extra);
        int kv0, la0, lb0, lm0, da, db, dm, obs;
        kv0 = kv_cnt; la0 = la_cnt; lb0 = lb_cnt; lm0 = lm_cnt;
        pressed = 16'h0;
        pressed[key_index(code)] = 1'b1;
        for (int i = 0; i < 200 && kv_cnt == kv0; i++) @(negedge clk);
        repeat (4 + hold_extra) @(negedge clk);
        pressed = 16'h0;
        repeat (24) @(negedge clk);
        da = la_cnt - la0; db = lb_cnt - lb0; dm = lm_cnt - lm0;
        if (da == 0 && db == 0 && dm == 0)      obs = 0;
        else if (da == 1 && db == 0 && dm == 0) obs = 1;
        else if (da == 0 && db == 1 && dm == 0) obs = 2;
        else if (da == 0 && db == 0 && dm == 1) obs = 3;
        else                                    obs = 9;
        check({tag, " key_valid count"}, kv_cnt - kv0, 1);
        check({tag, " key_code"}, int'(last_code), code);
        check({tag, " a"}, int'(a), exp_a);
        check({tag, " b"}, int'(b), exp_b);
        check({tag, " load kind"}, obs, exp_ld);
    endtask

    task automatic wait_col_enter(input logic [3:0] target, output int ok);
        logic [3:0] prev;
        ok = 0;
        prev = columna;
        for (int i = 0; i < 100 && ok == 0; i++) begin
            @(negedge clk);
            if (columna == target && prev != target) ok = 1;
            prev = columna;
        end
    endtask

    typedef struct {
        int code;
        int exp_a;
        int exp_b;
        int exp_ld;
    } vec_t;

    vec_t       vecs [13];
    logic [3:0] rot [4];

    initial begin
        int ok, ld, kv0, ls0, code;

        vecs[0]  = '{7,  7, 0, 1};
        vecs[1]  = '{14, 0, 0, 0};
        vecs[2]  = '{3,  3, 0, 1};
        vecs[3]  = '{5,  3, 5, 2};
        vecs[4]  = '{15, 3, 5, 3};
        vecs[5]  = '{8,  8, 5, 1};
        vecs[6]  = '{2,  8, 2, 2};
        vecs[7]  = '{10, 8, 2, 0};
        vecs[8]  = '{15, 8, 2, 3};
        vecs[9]  = '{14, 0, 0, 0};
        vecs[10] = '{15, 0, 0, 0};
        vecs[11] = '{3,  3, 0, 1};
        vecs[12] = '{14, 0, 0, 0};
        rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011; rot[3] = 4'b0111;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset columna", int'(columna), 4'b1110);
        check("reset key_valid", int'(key_valid), 0);
        check("reset key_code", int'(key_code), 0);
        check("reset a", int'(a), 0);
        check("reset b", int'(b), 0);
        check("reset loads", int'({load_a, load_b, load_m}), 0);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("rotation cycle %0d", k), int'(columna), int'(rot[(k / 4) % 4]));
        end

        // Bounce on '5': 2 ticks low, 1 tick high, 1 tick low
        wait_col_enter(4'b1101, ok);
        check("bounce column found", ok, 1);
        kv0 = kv_cnt; ls0 = la_cnt + lb_cnt + lm_cnt;
        pressed = 16'h0; pressed[key_index(5)] = 1'b1;
        repeat (8) @(negedge clk);
        pressed = 16'h0;
        repeat (4) @(negedge clk);
        pressed[key_index(5)] = 1'b1;
        repeat (4) @(negedge clk);
        pressed = 16'h0;
        repeat (30) @(negedge clk);
        check("bounce key_valid count", kv_cnt - kv0, 0);
        check("bounce a", int'(a), 0);
        check("bounce loads", la_cnt + lb_cnt + lm_cnt - ls0, 0);

        for (int i = 0; i < 13; i++) begin
            model_key(vecs[i].code, ld);
            press_and_check($sformatf("vec%0d", i), vecs[i].code, vecs[i].exp_a,
                            vecs[i].exp_b, vecs[i].exp_ld, i % 5);
        end

        // Two keys in column 0 together must be rejected
        kv0 = kv_cnt; ls0 = la_cnt + lb_cnt + lm_cnt;
        pressed = 16'h0;
        pressed[key_index(1)] = 1'b1;
        pressed[key_index(4)] = 1'b1;
        repeat (40) @(negedge clk);
        pressed = 16'h0;
        repeat (30) @(negedge clk);
        check("multikey key_valid count", kv_cnt - kv0, 0);
        check("multikey a", int'(a), m_a);
        check("multikey loads", la_cnt + lb_cnt + lm_cnt - ls0, 0);

        for (int i = 0; i < 24; i++) begin
            code = ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 15));
            model_key(code, ld);
            press_and_check($sformatf("rand%0d", i), code, m_a, m_b, ld,
                            int'($urandom_range(0, 20)));
        end

        // Reset while '7' is in debounce; the held key must then count as a fresh press
        wait_col_enter(4'b1110, ok);
        check("rst_debo column found", ok, 1);
        kv0 = kv_cnt;
        pressed = 16'h0; pressed[key_index(7)] = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_debo key_valid before", kv_cnt - kv0, 0);
        check("rst_debo columna", int'(columna), 4'b1110);
        check("rst_debo a", int'(a), 0);
        check("rst_debo b", int'(b), 0);
        model_reset();
        model_key(7, ld);
        press_and_check("rst_debo", 7, m_a, m_b, ld, 2);

        check("load latency violations", lat_err, 0);
        check("simultaneous load strobes", multi_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
